// File: rtl/tlb_refill_ctrl_pkg.sv
// Shared widths, field offsets, FSM encodings and response record for the
// TLB refill controller.
package tlb_refill_ctrl_pkg;

  localparam int ENTRY_W  = 79;
  localparam int IDX_W    = 6;
  localparam int VADDR_W  = 32;
  localparam int VPN2_LSB = 13;
  localparam int VPN2_W   = 19;
  localparam int ASID_W   = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_QUERY = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

  typedef struct packed {
    logic               hit;
    logic [IDX_W-1:0]   index;
    logic [ENTRY_W-1:0] entry;
  } l2_resp_t;

  // A MIPS TLB entry maps an even/odd page pair, so the match key drops bit 12.
  function automatic logic [VPN2_W-1:0] vpn2_of(input logic [VADDR_W-1:0] va);
    return va[VPN2_LSB +: VPN2_W];
  endfunction

endpackage

// File: rtl/tlb_refill_ctrl_rr_arb2.sv
// Two-way arbiter: alternates between ports on a tie, or always favours
// port 1 when fixed_prio is set. History advances only on an accepted grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       fixed_prio,
  input  logic       take,
  output logic [1:0] gnt
);

  logic last;  // 1 = port 1 won the last accepted grant

  always_comb begin
    gnt = req;
    if (req == 2'b11)
      gnt = (fixed_prio || !last) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      last <= 1'b0;
    else if (take && (gnt != 2'b00))
      last <= gnt[1];
  end

endmodule

// File: rtl/tlb_refill_ctrl.sv
// TLB refill controller: arbitrates I/D L1 TLB misses, queries the L2 TLB and
// loads the matching entry back into the requesting L1 or flags a refill trap.
module tlb_refill_ctrl
  import tlb_refill_ctrl_pkg::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_miss_req,
  input  logic               d_miss_req,
  input  logic [VADDR_W-1:0] i_miss_vaddr,
  input  logic [VADDR_W-1:0] d_miss_vaddr,
  output logic               i_miss_ack,
  output logic               d_miss_ack,
  output logic               i_miss_refill,
  output logic               d_miss_refill,
  input  logic [ASID_W-1:0]  asid,
  output logic               l2_q_valid,
  output logic [VPN2_W-1:0]  l2_q_vpn2,
  output logic [ASID_W-1:0]  l2_q_asid,
  input  logic               l2_r_hit,
  input  logic [IDX_W-1:0]   l2_r_index,
  input  logic [ENTRY_W-1:0] l2_r_entry,
  output logic [ENTRY_W-1:0] ld_tlb,
  output logic [IDX_W-1:0]   ld_index,
  output logic               ild_en,
  output logic               dld_en,
  input  logic               tlbw_busy,
  input  logic               flush
);

  logic [1:0]        state;
  side_e             side;
  logic [VPN2_W-1:0] vpn2;
  logic              stale;
  l2_resp_t          resp;

  logic [1:0] gnt;
  logic       grant_ok;
  logic       done;
  logic       req_live;
  logic       ack;
  logic       load;

  assign grant_ok = (state == ST_IDLE) && !flush && !tlbw_busy;

  rr_arb2 u_arb (
    .clk        (clk),
    .resetn     (resetn),
    .req        ({d_miss_req, i_miss_req}),
    .fixed_prio (ARB_MODE == 1),
    .take       (grant_ok),
    .gnt        (gnt)
  );

  // stale marks an L2 answer that a concurrent TLBWI/TLBWR may have overtaken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      side  <= SIDE_I;
      vpn2  <= '0;
      stale <= 1'b0;
      resp  <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      stale <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_ok && (gnt != 2'b00)) begin
            side  <= gnt[1] ? SIDE_D : SIDE_I;
            vpn2  <= vpn2_of(gnt[1] ? d_miss_vaddr : i_miss_vaddr);
            state <= ST_QUERY;
          end
        end
        ST_QUERY: begin
          stale <= tlbw_busy;
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (tlbw_busy) begin
            stale <= 1'b1;
          end else if (stale) begin
            stale <= 1'b0;
            state <= ST_QUERY;
          end else begin
            resp  <= '{hit: l2_r_hit, index: l2_r_index, entry: l2_r_entry};
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A requester that has withdrawn still gets its L1 loaded, but no ack.
  assign done     = (state == ST_DONE) && !flush;
  assign req_live = (side == SIDE_D) ? d_miss_req : i_miss_req;
  assign ack      = done && req_live;
  assign load     = done && resp.hit;

  assign i_miss_ack    = ack && (side == SIDE_I);
  assign d_miss_ack    = ack && (side == SIDE_D);
  assign i_miss_refill = i_miss_ack && !resp.hit;
  assign d_miss_refill = d_miss_ack && !resp.hit;

  assign ild_en   = load && (side == SIDE_I);
  assign dld_en   = load && (side == SIDE_D);
  assign ld_tlb   = load ? resp.entry : '0;
  assign ld_index = load ? resp.index : '0;

  assign l2_q_valid = (state == ST_QUERY);
  assign l2_q_vpn2  = l2_q_valid ? vpn2 : '0;
  assign l2_q_asid  = l2_q_valid ? asid : '0;

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Bench for tlb_refill_ctrl: an L2 table model answers queries, and each
// refill is predicted at transaction level from that table and the arbitration rule.
module tb_tlb_refill_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_miss_req, d_miss_req;
  logic [31:0] i_miss_vaddr, d_miss_vaddr;
  logic        i_miss_ack, d_miss_ack, i_miss_refill, d_miss_refill;
  logic [7:0]  asid;
  logic        l2_q_valid;
  logic [18:0] l2_q_vpn2;
  logic [7:0]  l2_q_asid;
  logic        l2_r_hit;
  logic [5:0]  l2_r_index;
  logic [78:0] l2_r_entry;
  logic [78:0] ld_tlb;
  logic [5:0]  ld_index;
  logic        ild_en, dld_en;
  logic        tlbw_busy, flush;

  logic        u1_i_ack, u1_d_ack, u1_i_refill, u1_d_refill, u1_q_valid;
  logic [18:0] u1_q_vpn2;
  logic [7:0]  u1_q_asid;
  logic [78:0] u1_ld_tlb;
  logic [5:0]  u1_ld_index;
  logic        u1_ild_en, u1_dld_en;

  int total = 0;
  int bad   = 0;
  bit last_d;

  logic [18:0] t_v [8];
  logic [7:0]  t_a [8];
  logic [5:0]  t_i [8];
  logic [78:0] t_e [8];

  logic        q_seen = 1'b0;
  logic [18:0] q_vpn2 = '0;
  logic [7:0]  q_asid = '0;

  always #5 clk = ~clk;

  tlb_refill_ctrl #(.ARB_MODE(0)) dut (
    .clk(clk), .resetn(resetn),
    .i_miss_req(i_miss_req), .d_miss_req(d_miss_req),
    .i_miss_vaddr(i_miss_vaddr), .d_miss_vaddr(d_miss_vaddr),
    .i_miss_ack(i_miss_ack), .d_miss_ack(d_miss_ack),
    .i_miss_refill(i_miss_refill), .d_miss_refill(d_miss_refill),
    .asid(asid),
    .l2_q_valid(l2_q_valid), .l2_q_vpn2(l2_q_vpn2), .l2_q_asid(l2_q_asid),
    .l2_r_hit(l2_r_hit), .l2_r_index(l2_r_index), .l2_r_entry(l2_r_entry),
    .ld_tlb(ld_tlb), .ld_index(ld_index), .ild_en(ild_en), .dld_en(dld_en),
    .tlbw_busy(tlbw_busy), .flush(flush)
  );

  tlb_refill_ctrl #(.ARB_MODE(1)) dut_fixed (
    .clk(clk), .resetn(resetn),
    .i_miss_req(i_miss_req), .d_miss_req(d_miss_req),
    .i_miss_vaddr(i_miss_vaddr), .d_miss_vaddr(d_miss_vaddr),
    .i_miss_ack(u1_i_ack), .d_miss_ack(u1_d_ack),
    .i_miss_refill(u1_i_refill), .d_miss_refill(u1_d_refill),
    .asid(asid),
    .l2_q_valid(u1_q_valid), .l2_q_vpn2(u1_q_vpn2), .l2_q_asid(u1_q_asid),
    .l2_r_hit(l2_r_hit), .l2_r_index(l2_r_index), .l2_r_entry(l2_r_entry),
    .ld_tlb(u1_ld_tlb), .ld_index(u1_ld_index), .ild_en(u1_ild_en), .dld_en(u1_dld_en),
    .tlbw_busy(tlbw_busy), .flush(flush)
  );

  function automatic void lookup(input logic [18:0] v, input logic [7:0] a,
                                 output bit h, output int s);
    h = 1'b0;
    s = 0;
    for (int k = 0; k < 8; k++)
      if (!h && t_v[k] == v && t_a[k] == a) begin
        h = 1'b1;
        s = k;
      end
  endfunction

  function automatic logic [78:0] rnd_entry();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[78:0];
  endfunction

  // L2 TLB: answers exactly one cycle after a query, junk on every other cycle.
  always @(posedge clk) begin
    q_seen <= l2_q_valid;
    q_vpn2 <= l2_q_vpn2;
    q_asid <= l2_q_asid;
  end

  always @(negedge clk) begin
    bit h;
    int s;
    lookup(q_vpn2, q_asid, h, s);
    l2_r_hit   <= q_seen ? h : 1'($urandom);
    l2_r_index <= (q_seen && h) ? t_i[s] : 6'($urandom);
    l2_r_entry <= (q_seen && h) ? t_e[s] : rnd_entry();
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int c;
    @(posedge clk);
    #1;
    c = int'(ild_en) + int'(dld_en) + int'(i_miss_ack) + int'(d_miss_ack);
    chk("exclusive", (c <= 1) || (c == 2 && ((ild_en && i_miss_ack) || (dld_en && d_miss_ack))), 1'b1);
    if (!ild_en && !dld_en) chk("ld_bus_zero", {ld_index, ld_tlb}, '0);
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {i_miss_ack, d_miss_ack, ild_en, dld_en, i_miss_refill, d_miss_refill}, '0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, {i_miss_ack, d_miss_ack, i_miss_refill, d_miss_refill, ild_en, dld_en,
                      ld_index, l2_q_valid, l2_q_vpn2, l2_q_asid}, '0);
    chk({tag, "_b"}, ld_tlb, '0);
  endtask

  // side: 1 = D. Waits for the completion and checks it against the L2 table.
  task automatic wait_ack(input string tag, input bit side, input logic [31:0] va, input int lat);
    bit h;
    int s;
    int n;
    lookup(va[31:13], asid, h, s);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(i_miss_ack || d_miss_ack || ild_en || dld_en) && n < 12);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_ack"}, {i_miss_ack, d_miss_ack}, side ? 2'b01 : 2'b10);
    chk({tag, "_refill"}, {i_miss_refill, d_miss_refill}, h ? 2'b00 : (side ? 2'b01 : 2'b10));
    chk({tag, "_lden"}, {ild_en, dld_en}, !h ? 2'b00 : (side ? 2'b01 : 2'b10));
    if (h) begin
      chk({tag, "_idx"}, ld_index, t_i[s]);
      chk({tag, "_entry"}, ld_tlb, t_e[s]);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    i_miss_req = 1'b0;
    d_miss_req = 1'b0;
    tlbw_busy = 1'b0;
    flush = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    last_d = 1'b0;
  endtask

  initial begin
    logic [31:0] va, va_i, va_d;
    bit h;
    int s;

    resetn = 1'b0;
    i_miss_req = 1'b0;
    d_miss_req = 1'b0;
    i_miss_vaddr = '0;
    d_miss_vaddr = '0;
    asid = 8'h00;
    tlbw_busy = 1'b0;
    flush = 1'b0;
    for (int k = 0; k < 8; k++) begin
      t_v[k] = 19'($urandom_range(19'h10000, 19'h7FFFF));
      t_a[k] = 8'($urandom);
      t_i[k] = 6'(k * 7 + 1);
      t_e[k] = rnd_entry();
    end
    t_v[0] = 19'h00201;
    t_a[0] = 8'h2A;
    t_i[0] = 6'd5;

    #1;
    chk_all_zero("reset");
    do_reset();
    chk_all_zero("post_reset");

    // D-side hit at 0x0040_2000 on L2 index 5
    asid = 8'h2A;
    d_miss_vaddr = 32'h0040_2000;
    d_miss_req = 1'b1;
    wait_ack("d_hit", 1'b1, d_miss_vaddr, 3);
    chk("d_hit_idx5", {dld_en, ld_index}, {1'b1, 6'd5});
    d_miss_req = 1'b0;
    last_d = 1'b1;
    tick();

    // I-side miss raises the refill exception
    i_miss_vaddr = 32'h1000_0000;
    i_miss_req = 1'b1;
    wait_ack("i_miss", 1'b0, i_miss_vaddr, 3);
    chk("i_miss_flag", {i_miss_refill, ild_en}, 2'b10);
    i_miss_req = 1'b0;
    last_d = 1'b0;
    tick();

    // Ties: round-robin gives D, I, D; fixed priority keeps picking D
    do_reset();
    asid = 8'h33;
    i_miss_vaddr = 32'h2000_4000;
    d_miss_vaddr = 32'h3000_8000;
    i_miss_req = 1'b1;
    d_miss_req = 1'b1;
    wait_ack("arb1", 1'b1, d_miss_vaddr, 3);
    chk("arb1_fixed", {u1_i_ack, u1_d_ack}, 2'b01);
    d_miss_req = 1'b0;
    tick();
    d_miss_req = 1'b1;
    wait_ack("arb2", 1'b0, i_miss_vaddr, 3);
    chk("arb2_fixed", {u1_i_ack, u1_d_ack}, 2'b01);
    i_miss_req = 1'b0;
    wait_ack("arb3", 1'b1, d_miss_vaddr, 4);
    d_miss_req = 1'b0;
    tick();
    do_reset();

    // Flush in RESP aborts, flush in IDLE blocks a grant, then normal service
    asid = t_a[1];
    d_miss_vaddr = {t_v[1], 13'h0123};
    d_miss_req = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    chk_quiet("flush_abort");
    chk("flush_abort_q", l2_q_valid, 1'b0);
    tick();
    chk("flush_blocks_grant", l2_q_valid, 1'b0);
    chk_quiet("flush_idle");
    flush = 1'b0;
    d_miss_req = 1'b0;
    tick();
    d_miss_req = 1'b1;
    wait_ack("flush_reraise", 1'b1, d_miss_vaddr, 3);
    d_miss_req = 1'b0;
    last_d = 1'b1;
    tick();

    // Requester withdraws before ack: L1 still loaded, ack discarded
    asid = t_a[2];
    i_miss_vaddr = {t_v[2], 13'h1FFF};
    i_miss_req = 1'b1;
    tick();
    tick();
    i_miss_req = 1'b0;
    tick();
    chk("drop_no_ack", {i_miss_ack, d_miss_ack}, 2'b00);
    chk("drop_load", {ild_en, dld_en, ld_index}, {2'b10, t_i[2]});
    last_d = 1'b0;
    tick();

    // TLBW in flight during QUERY forces a second query with fresh L2 contents
    asid = t_a[3];
    i_miss_vaddr = {t_v[3], 13'h0040};
    i_miss_req = 1'b1;
    tick();
    chk("busy_q1", {l2_q_valid, l2_q_vpn2, l2_q_asid}, {1'b1, t_v[3], t_a[3]});
    tlbw_busy = 1'b1;
    t_i[3] = 6'd61;
    t_e[3] = rnd_entry();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("busy_hold", {l2_q_valid, i_miss_ack, ild_en}, 3'b000);
    end
    tlbw_busy = 1'b0;
    tick();
    chk("busy_q2", {l2_q_valid, l2_q_vpn2}, {1'b1, t_v[3]});
    wait_ack("busy_resp2", 1'b0, i_miss_vaddr, 2);
    i_miss_req = 1'b0;
    last_d = 1'b0;
    tick();

    // Reset while ack is showing drops outputs at once, nothing stale after
    asid = t_a[4];
    d_miss_vaddr = {t_v[4], 13'h0004};
    d_miss_req = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_pre_ack", {d_miss_ack, dld_en}, 2'b11);
    resetn = 1'b0;
    #1;
    chk_all_zero("rst_async");
    d_miss_req = 1'b0;
    tick();
    resetn = 1'b1;
    last_d = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_quiet("rst_no_stale");
    end

    // Random traffic against the transaction-level model
    for (int it = 0; it < 40; it++) begin
      int mode;
      bit win;
      mode = $urandom_range(0, 2);
      s = $urandom_range(0, 7);
      asid = ($urandom_range(0, 1) == 1) ? t_a[s] : 8'($urandom);
      va_i = ($urandom_range(0, 1) == 1) ? {t_v[s], 13'($urandom)} : $urandom;
      va_d = ($urandom_range(0, 1) == 1) ? {t_v[$urandom_range(0, 7)], 13'($urandom)} : $urandom;
      i_miss_vaddr = va_i;
      d_miss_vaddr = va_d;
      i_miss_req = (mode != 1);
      d_miss_req = (mode != 0);
      win = (mode == 2) ? !last_d : (mode == 1);
      last_d = win;
      wait_ack("rnd_first", win, win ? va_d : va_i, 3);
      if (win) d_miss_req = 1'b0;
      else     i_miss_req = 1'b0;
      if (mode == 2) begin
        last_d = !win;
        wait_ack("rnd_second", !win, win ? va_i : va_d, 4);
        i_miss_req = 1'b0;
        d_miss_req = 1'b0;
      end
      tick();
    end

    lookup(19'h00201, 8'h2A, h, s);
    va = 32'h0040_2000;
    asid = 8'h2A;
    d_miss_vaddr = va;
    d_miss_req = 1'b1;
    wait_ack("final_d_hit", 1'b1, va, (last_d ? 3 : 3));
    d_miss_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
